ocimem_access_scheduler: RTL and testbench
==========================================

# ocimem_access_scheduler

Sysclk-domain scheduler that shares the debug slave's single-port on-chip-instrumentation (OCI) RAM between two requesters: JTAG debug commands, which arrive as one-cycle `take_action_*` strobes with a `jdo` payload, and a CPU-side Avalon-MM slave port. It latches JTAG strobes into a pending request and arbitrates round-robin against CPU transfers. It sequences each RAM access through a 3-state FSM and returns read data to `MonDReg`/`monitor_ready` for the JTAG side, or to `avs_readdata` for the CPU. It sits between the debug slave sysclk block and the OCI RAM instance.

## Interface
- `ADDR_W`, 8, RAM word-address width.
- `DATA_W`, 32, RAM data width (≤ 36).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `jdo`  in  38  JTAG command payload; sampled only on a strobe.
- `take_action_ocimem_a`  in  1  strobe: load JTAG address from `jdo[ADDR_W-1:0]`, then read it; `jdo[37]`=1 also clears `monitor_error`.
- `take_action_ocimem_b`  in  1  strobe: write `jdo[DATA_W-1:0]` at the JTAG address, then post-increment the address.
- `take_no_action_ocimem_a`  in  1  strobe: read at the JTAG address, then post-increment the address.
- `avs_address`  in  ADDR_W  CPU word address.
- `avs_read`, `avs_write`  in  1  CPU request; held until accepted.
- `avs_writedata`  in  DATA_W  CPU write data.
- `avs_waitrequest`  out  1  combinational; low only in the cycle the CPU request is granted.
- `avs_readdata`  out  DATA_W  registered read data.
- `avs_readdatavalid`  out  1  one-cycle pulse.
- `ram_addr`  out  ADDR_W  registered.
- `ram_wr`  out  1  registered.
- `ram_wdata`  out  DATA_W  registered.
- `ram_rdata`  in  DATA_W  RAM read data; 1-cycle latency after address.
- `MonDReg`  out  DATA_W  last JTAG read result.
- `monitor_ready`  out  1  high from completion of a JTAG access until the next JTAG strobe.
- `monitor_error`  out  1  sticky overrun flag.

## Operation
- JTAG command register:
  - Any strobe while no JTAG request is pending sets `jtag_pend` and stores op/data, and clears `monitor_ready`.
  - A strobe while `jtag_pend` is set, or while a JTAG access is in flight, is dropped and sets `monitor_error`.
  - Strobes are one-hot; if more than one asserts, priority is ocimem_a > ocimem_b > no_action_a.
- `jtag_addr` is wrapped modulo 2^ADDR_W: 0xFF+1 → 0x00 for ADDR_W=8.
  - ocimem_a loads `jtag_addr` at the strobe edge.
  - Post-increment happens at the end of the ACCESS cycle.
- FSM states: IDLE, ACCESS, CAPTURE.
  - IDLE: if only one requester is pending, grant it. If both are pending, grant the requester not served last; `last_grant` resets to CPU, so JTAG wins the first tie. On grant, register `ram_addr`/`ram_wr`/`ram_wdata` and go to ACCESS.
  - ACCESS: RAM samples. A write returns to IDLE (JTAG write also sets `monitor_ready`). A read goes to CAPTURE.
  - CAPTURE: register `ram_rdata` into `MonDReg`, set `monitor_ready` (JTAG), or into `avs_readdata` with `avs_readdatavalid`=1 (CPU). Return to IDLE.
- `ram_wr` is high only during the ACCESS cycle of a write.
- Reset values:
  - FSM = IDLE; `jtag_pend`=0; `jtag_addr`=0; `last_grant`=CPU.
  - `ram_addr`/`ram_wdata`=0; `ram_wr`=0.
  - `MonDReg`/`avs_readdata`=0; `avs_readdatavalid`=0.
  - `monitor_ready`=0; `monitor_error`=0.
- Reset mid-access: abandon the access at the next edge, with no readdatavalid or ready. A CPU master waiting on `avs_waitrequest` sees it high until re-granted after reset.

## Timing
- JTAG strobe sampled at edge T:
  - `jtag_pend` is high in T+1; grant is in T+1 if IDLE.
  - ACCESS is T+2; CAPTURE is T+3.
  - `monitor_ready` and `MonDReg` update at T+4 (read); `monitor_ready` rises at T+3 (write).
- CPU request granted in cycle G (waitrequest low in G):
  - ACCESS is G+1.
  - `avs_readdatavalid` pulses in G+3 (read).
- Throughput:
  - Read occupancy is 3 cycles (IDLE, ACCESS, CAPTURE); write occupancy is 2 cycles.
  - Back-to-back alternating grants occur when both requesters are continuously pending.
- No combinational path from `ram_rdata` to any output.

## Test plan
- ocimem_a with `jdo[7:0]`=0x10 and RAM[0x10]=0xDEADBEEF:
  - `MonDReg`=0xDEADBEEF and `monitor_ready`=1 four cycles after the strobe.
  - `jtag_addr`=0x11.
- Write burst: ocimem_a addr=0xFE, then ocimem_b ×3 with data 1, 2, 3 spaced ≥4 cycles apart:
  - RAM[0xFF]=1, RAM[0x00]=2, RAM[0x01]=3, showing wrap.
  - `monitor_error`=0.
- CPU read of addr 0x05 (RAM=0x1234) held from cycle 0 with JTAG idle:
  - waitrequest low in cycle 0.
  - readdatavalid with 0x1234 in cycle 3.
- JTAG strobe and CPU write pending in the same IDLE cycle after reset:
  - JTAG is granted first; the CPU is granted on the next IDLE.
  - With both held continuously, grants alternate.
- Second ocimem_b strobe one cycle after the first:
  - The second is dropped and `monitor_error`=1.
  - A later ocimem_a with `jdo[37]`=1 clears `monitor_error`.
- Reset asserted during the ACCESS cycle of a CPU read:
  - No readdatavalid; all outputs return to reset values next cycle.
  - The re-asserted read completes normally afterward.

Source files
------------

// File: rtl/ocimem_access_scheduler.sv
// Shares the single-port OCI RAM between JTAG debug commands and a CPU
// Avalon-MM slave, round-robin arbitrated through an IDLE/ACCESS/CAPTURE FSM.
module ocimem_access_scheduler #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE
  } state_e;

  state_e state_q, state_d;

  logic              jpend_q, jpend_d;
  logic              jwr_q, jwr_d;
  logic [DATA_W-1:0] jdata_q, jdata_d;
  logic [ADDR_W-1:0] jaddr_q, jaddr_d;
  logic              last_jtag_q, last_jtag_d;
  logic              own_jtag_q, own_jtag_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_wr_q, ram_wr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] mon_q, mon_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] avs_rdata_q, avs_rdata_d;
  logic              avs_rdv_q, avs_rdv_d;

  logic strobe;
  logic jbusy;
  logic cpu_req;
  logic grant_j;
  logic grant_c;
  logic unused_jdo;

  assign unused_jdo = ^jdo;

  assign strobe  = take_action_ocimem_a | take_action_ocimem_b
                 | take_no_action_ocimem_a;
  assign jbusy   = jpend_q | ((state_q != S_IDLE) & own_jtag_q);
  assign cpu_req = avs_read | avs_write;
  // On a tie the requester not served last wins.
  assign grant_j = (state_q == S_IDLE) & jpend_q
                 & (~cpu_req | ~last_jtag_q);
  assign grant_c = (state_q == S_IDLE) & cpu_req & ~grant_j;

  assign avs_waitrequest = ~(grant_c & ~reset);

  always_comb begin
    state_d     = state_q;
    jpend_d     = jpend_q;
    jwr_d       = jwr_q;
    jdata_d     = jdata_q;
    jaddr_d     = jaddr_q;
    last_jtag_d = last_jtag_q;
    own_jtag_d  = own_jtag_q;
    rd_d        = rd_q;
    ram_addr_d  = ram_addr_q;
    ram_wr_d    = ram_wr_q;
    ram_wdata_d = ram_wdata_q;
    mon_d       = mon_q;
    rdy_d       = rdy_q;
    err_d       = err_q;
    avs_rdata_d = avs_rdata_q;
    avs_rdv_d   = 1'b0;

    if (strobe) begin
      if (jbusy) begin
        err_d = 1'b1;
      end else begin
        jpend_d = 1'b1;
        rdy_d   = 1'b0;
        jwr_d   = ~take_action_ocimem_a & take_action_ocimem_b;
        jdata_d = jdo[DATA_W-1:0];
        if (take_action_ocimem_a) begin
          jaddr_d = jdo[ADDR_W-1:0];
          if (jdo[37]) err_d = 1'b0;
        end
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (grant_j) begin
          state_d     = S_ACCESS;
          last_jtag_d = 1'b1;
          own_jtag_d  = 1'b1;
          jpend_d     = 1'b0;
          ram_addr_d  = jaddr_q;
          ram_wr_d    = jwr_q;
          ram_wdata_d = jdata_q;
          rd_d        = ~jwr_q;
        end else if (grant_c) begin
          state_d     = S_ACCESS;
          last_jtag_d = 1'b0;
          own_jtag_d  = 1'b0;
          ram_addr_d  = avs_address;
          ram_wr_d    = avs_write;
          ram_wdata_d = avs_writedata;
          rd_d        = ~avs_write;
        end
      end
      S_ACCESS: begin
        ram_wr_d = 1'b0;
        if (own_jtag_q) jaddr_d = jaddr_q + 1'b1;
        if (rd_q) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_IDLE;
          if (own_jtag_q) rdy_d = 1'b1;
        end
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
        if (own_jtag_q) begin
          mon_d = ram_rdata;
          rdy_d = 1'b1;
        end else begin
          avs_rdata_d = ram_rdata;
          avs_rdv_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      jpend_q     <= 1'b0;
      jwr_q       <= 1'b0;
      jdata_q     <= '0;
      jaddr_q     <= '0;
      last_jtag_q <= 1'b0;
      own_jtag_q  <= 1'b0;
      rd_q        <= 1'b0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_wdata_q <= '0;
      mon_q       <= '0;
      rdy_q       <= 1'b0;
      err_q       <= 1'b0;
      avs_rdata_q <= '0;
      avs_rdv_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      jpend_q     <= jpend_d;
      jwr_q       <= jwr_d;
      jdata_q     <= jdata_d;
      jaddr_q     <= jaddr_d;
      last_jtag_q <= last_jtag_d;
      own_jtag_q  <= own_jtag_d;
      rd_q        <= rd_d;
      ram_addr_q  <= ram_addr_d;
      ram_wr_q    <= ram_wr_d;
      ram_wdata_q <= ram_wdata_d;
      mon_q       <= mon_d;
      rdy_q       <= rdy_d;
      err_q       <= err_d;
      avs_rdata_q <= avs_rdata_d;
      avs_rdv_q   <= avs_rdv_d;
    end
  end

  assign ram_addr          = ram_addr_q;
  assign ram_wr            = ram_wr_q;
  assign ram_wdata         = ram_wdata_q;
  assign MonDReg           = mon_q;
  assign monitor_ready     = rdy_q;
  assign monitor_error     = err_q;
  assign avs_readdata      = avs_rdata_q;
  assign avs_readdatavalid = avs_rdv_q;

endmodule

// File: tb/tb_ocimem_access_scheduler.sv
// Scoreboard bench: stimulus pushes expected read data and arrival cycle,
// a monitor pops them on readdatavalid / monitor_ready rising.
module tb_ocimem_access_scheduler;

  localparam int KA  = 0;
  localparam int KB  = 1;
  localparam int KNA = 2;

  logic        clk;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [7:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [7:0]  ram_addr;
  logic        ram_wr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t jq[$];
  exp_t cq[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic init;
  logic prev_rdy = 1'b0;
  logic [31:0] mem [256];

  ocimem_access_scheduler dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_waitrequest         (avs_waitrequest),
    .avs_readdata            (avs_readdata),
    .avs_readdatavalid       (avs_readdatavalid),
    .ram_addr                (ram_addr),
    .ram_wr                  (ram_wr),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    case (a)
      8'h10:   return 32'hDEADBEEF;
      8'h11:   return 32'hA5A50011;
      8'hFE:   return 32'hCAFE00FE;
      8'h05:   return 32'h00001234;
      default: return {8'h5A, 16'h0000, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
    end else if (ram_wr) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (avs_readdatavalid) begin
      if (cq.size() == 0) begin
        chk("cpu_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = cq.pop_front();
        chk("cpu_rdata", avs_readdata, e.data);
        chk("cpu_valid_cyc", cyc, e.cyc);
      end
    end
    if (monitor_ready && !prev_rdy) begin
      if (jq.size() == 0) begin
        chk("jtag_unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = jq.pop_front();
        chk("jtag_mondreg", MonDReg, e.data);
        chk("jtag_ready_cyc", cyc, e.cyc);
      end
    end
    prev_rdy = monitor_ready;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) next();
  endtask

  task automatic strobe(input int kind, input logic [37:0] d);
    jdo = d;
    take_action_ocimem_a    = (kind == KA);
    take_action_ocimem_b    = (kind == KB);
    take_no_action_ocimem_a = (kind == KNA);
    next();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo = '0;
  endtask

  task automatic cpu_grant(output int g);
    bit ok;
    ok = 1'b0;
    g  = -1;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (!avs_waitrequest) begin
        g  = cyc;
        ok = 1'b1;
      end
      next();
    end
    if (!ok) chk("cpu_grant_timeout", 32'd0, 32'd1);
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  int n;
  int g;
  int s;

  initial begin
    reset = 1'b1;
    init  = 1'b1;
    jdo   = '0;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    idle(2);
    init = 1'b0;
    idle(1);
    @(negedge clk);
    chk("rst_ready", monitor_ready, 0);
    chk("rst_error", monitor_error, 0);
    chk("rst_mondreg", MonDReg, 0);
    chk("rst_rdv", avs_readdatavalid, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_waitreq", avs_waitrequest, 1);
    next();
    reset = 1'b0;
    idle(1);

    // single JTAG read, then read-next proves the post-increment
    n = cyc;
    jq.push_back(exp_t'{32'hDEADBEEF, n + 4});
    strobe(KA, 38'h10);
    idle(6);
    n = cyc;
    jq.push_back(exp_t'{32'hA5A50011, n + 4});
    strobe(KNA, 38'h0);
    idle(6);

    // write burst across the address wrap
    n = cyc;
    jq.push_back(exp_t'{32'hCAFE00FE, n + 4});
    strobe(KA, 38'hFE);
    idle(6);
    for (int v = 1; v <= 3; v++) begin
      n = cyc;
      jq.push_back(exp_t'{32'hCAFE00FE, n + 3});
      strobe(KB, 38'(v));
      idle(5);
    end
    chk("wr_mem_ff", mem[8'hFF], 32'd1);
    chk("wr_mem_00", mem[8'h00], 32'd2);
    chk("wr_mem_01", mem[8'h01], 32'd3);
    chk("wr_no_error", monitor_error, 0);

    // plain CPU read
    n = cyc;
    avs_read    = 1'b1;
    avs_address = 8'h05;
    cpu_grant(g);
    chk("cpu_grant_cyc", g, n);
    cq.push_back(exp_t'{32'h00001234, g + 3});
    idle(5);

    // tie after reset: JTAG first, CPU on the next IDLE
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    n = cyc;
    jq.push_back(exp_t'{32'h5A000030, n + 4});
    strobe(KA, 38'h30);
    avs_write     = 1'b1;
    avs_address   = 8'h20;
    avs_writedata = 32'h77;
    cpu_grant(g);
    chk("tie_cpu_grant_cyc", g, n + 4);
    idle(4);
    chk("tie_cpu_wr_mem", mem[8'h20], 32'h77);
    idle(3);

    // both continuously requesting: grants alternate
    s = cyc;
    fork
      begin
        int k;
        k = 0;
        avs_read    = 1'b1;
        avs_address = 8'h05;
        for (int t = 0; t < 40 && k < 3; t++) begin
          @(negedge clk);
          if (!avs_waitrequest) begin
            chk("alt_cpu_grant_cyc", cyc, s + 6 * k);
            cq.push_back(exp_t'{32'h00001234, cyc + 3});
            k++;
          end
          next();
        end
        avs_read = 1'b0;
        chk("alt_cpu_count", k, 3);
      end
      begin
        for (int j = 0; j < 3; j++) begin
          while (cyc < s + 6 * j) next();
          jq.push_back(exp_t'{32'h5A000031 + 32'(j), s + 6 + 6 * j});
          strobe(KNA, 38'h0);
        end
      end
    join
    idle(10);
    chk("alt_no_error", monitor_error, 0);

    // overrun: second strobe one cycle later is dropped
    n = cyc;
    jq.push_back(exp_t'{32'h5A000033, n + 3});
    strobe(KB, 38'hB1);
    strobe(KB, 38'hB2);
    @(negedge clk);
    chk("ovr_error_set", monitor_error, 1);
    idle(4);
    chk("ovr_mem_34", mem[8'h34], 32'hB1);
    chk("ovr_mem_35", mem[8'h35], 32'h5A000035);
    n = cyc;
    jq.push_back(exp_t'{32'h5A000040, n + 4});
    strobe(KA, {1'b1, 29'h0, 8'h40});
    @(negedge clk);
    chk("ovr_error_clr", monitor_error, 0);
    idle(5);

    // reset during ACCESS of a CPU read
    avs_read    = 1'b1;
    avs_address = 8'h05;
    cpu_grant(g);
    reset = 1'b1;
    next();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_rdv", avs_readdatavalid, 0);
    chk("mid_rst_rdata", avs_readdata, 0);
    chk("mid_rst_mondreg", MonDReg, 0);
    chk("mid_rst_ready", monitor_ready, 0);
    chk("mid_rst_ram_addr", ram_addr, 0);
    chk("mid_rst_ram_wr", ram_wr, 0);
    idle(4);
    n = cyc;
    avs_read    = 1'b1;
    avs_address = 8'h05;
    cpu_grant(g);
    chk("rerd_grant_cyc", g, n);
    cq.push_back(exp_t'{32'h00001234, g + 3});
    idle(6);

    chk("sb_jtag_drained", jq.size(), 0);
    chk("sb_cpu_drained", cq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
